// File: rtl/audio_dequant_out_pkg.sv
// Shared fixed-point audio constants and the PCM saturation helper.
package audio_dequant_out_pkg;

    localparam int BITS            = 10;
    localparam int AUDIO_SAMPLES   = 32768;
    localparam int DEQUANT_SHIFT   = 2 * BITS;
    localparam int AUDIO_OUT_WIDTH = 16;

    // Clamp a wide signed value into the signed range of a w-bit integer.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/audio_sat_round.sv
// Truncate-toward-zero dequantize of a Q(2*BITS) product, then clamp to PCM width.
module audio_sat_round
    import audio_dequant_out_pkg::*;
#(
    parameter int BITS       = audio_dequant_out_pkg::BITS,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = audio_dequant_out_pkg::AUDIO_OUT_WIDTH
) (
    input  logic signed [2*DATA_WIDTH-1:0] prod,
    output logic signed [OUT_WIDTH-1:0]    q,
    output logic                           clip
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int SHIFT = 2 * BITS;
    // Adding 2^SHIFT-1 to negatives turns the floor of >>> into truncation toward zero.
    localparam logic [PW:0] RND = ((PW + 1)'(1) << SHIFT) - (PW + 1)'(1);

    logic signed [PW:0] biased;
    logic signed [PW:0] shifted;
    logic signed [63:0] q_full;
    logic signed [63:0] q_sat;

    // One extra bit of headroom so the rounding bias can never overflow.
    always_comb begin
        biased = {prod[PW-1], prod} + (prod[PW-1] ? RND : '0);
        shifted = biased >>> SHIFT;
        q_full  = 64'(shifted);
        q_sat   = sat_s(q_full, OUT_WIDTH);
        q       = q_sat[OUT_WIDTH-1:0];
        clip    = (q_sat != q_full);
    end

endmodule

// File: rtl/audio_dequant_out.sv
// Output end of the audio path: gain, dequantize, saturate, stream out, count blocks.
module audio_dequant_out
    import audio_dequant_out_pkg::*;
#(
    parameter int BITS        = audio_dequant_out_pkg::BITS,
    parameter int DATA_WIDTH  = 32,
    parameter int OUT_WIDTH   = audio_dequant_out_pkg::AUDIO_OUT_WIDTH,
    parameter int NUM_SAMPLES = audio_dequant_out_pkg::AUDIO_SAMPLES
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] din,
    input  logic signed [DATA_WIDTH-1:0] volume,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  dout,
    output logic                         sat,
    output logic                         block_done
);

    localparam int STAGES = 2;
    localparam int PW     = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(NUM_SAMPLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);

    logic [STAGES:1]          vld_pipe;
    logic signed [PW-1:0]     prod_q;
    logic signed [OUT_WIDTH-1:0] q_sat;
    logic                     clip;
    logic                     en;
    logic                     hs;
    logic [CNT_W-1:0]         cnt;

    // Whole pipeline moves together whenever the output slot is free or draining.
    assign en         = !vld_pipe[STAGES] || out_ready;
    assign in_ready   = en;
    assign out_valid  = vld_pipe[STAGES];
    assign hs         = out_valid && out_ready;
    assign block_done = hs && (cnt == LAST);

    audio_sat_round #(
        .BITS       (BITS),
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_sat_round (
        .prod (prod_q),
        .q    (q_sat),
        .clip (clip)
    );

    // Stage 1 holds the full-precision product; stage 2 is the PCM output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            prod_q   <= '0;
            dout     <= '0;
            sat      <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid)
                prod_q <= PW'(din) * PW'(volume);
            if (vld_pipe[1]) begin
                dout <= q_sat;
                if (clip)
                    sat <= 1'b1;
            end
        end
    end

    // Delivered-sample counter, wrapping on the last sample of each block.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (hs)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

endmodule

// File: tb/tb_audio_dequant_out.sv
// Scoreboard bench for audio_dequant_out with a 4-sample block.
module tb_audio_dequant_out;

    localparam int NS = 4;

    typedef struct {
        logic signed [15:0] val;
        bit                 clip;
        int                 acc_cyc;
    } exp_t;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] din;
    logic signed [31:0] volume;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] dout;
    logic               sat;
    logic               block_done;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    bit   exp_sat = 0;
    bit   chk_lat = 0;
    int   bd_seen = 0;
    logic signed [15:0] last_val = 0;

    audio_dequant_out #(.NUM_SAMPLES(NS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .volume     (volume),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .sat        (sat),
        .block_done (block_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact division truncates toward zero, then clamp to int16.
    function automatic exp_t model(input logic signed [31:0] d, input logic signed [31:0] v);
        exp_t   e;
        longint p, t;
        p = longint'(d) * longint'(v);
        t = p / (64'sd1 <<< 20);
        e.clip = (t > 32767) || (t < -32768);
        if (t > 32767)       t = 32767;
        else if (t < -32768) t = -32768;
        e.val = 16'(t);
        e.acc_cyc = 0;
        return e;
    endfunction

    // One clock: drive at negedge, observe handshakes, then let the posedge happen.
    task automatic step(input logic v, input logic signed [31:0] d, input logic signed [31:0] vol,
                        input logic rdy, output bit acc);
        exp_t e;
        bit   hs;
        @(negedge clock);
        in_valid = v; din = d; volume = vol; out_ready = rdy;
        #1;
        hs  = out_valid && out_ready;
        acc = in_valid && in_ready;
        if (out_valid && !out_ready) chk("in_ready_bp", in_ready, 0);
        chk("block_done", block_done, hs && (hs_cnt % NS == NS - 1));
        if (hs && block_done) bd_seen++;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = sb.pop_front();
                exp_sat = exp_sat | e.clip;
                chk("dout", dout, e.val);
                chk("sat", sat, exp_sat);
                if (chk_lat) chk("latency", cyc - e.acc_cyc, 2);
                last_val = dout;
            end
            hs_cnt++;
        end
        if (acc) begin
            e = model(d, vol);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        cyc++;
    endtask

    task automatic drain(input bit rand_rdy);
        bit a;
        int guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            step(0, 0, 1024, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, a);
            guard++;
        end
        chk("drain_empty", sb.size(), 0);
        step(0, 0, 1024, 1, a);
    endtask

    initial begin
        bit a;
        int idx;
        int guard;
        reset_n = 0; in_valid = 0; din = 0; volume = 0; out_ready = 0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_sat", sat, 0);
        chk("rst_block_done", block_done, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clock); reset_n = 1;

        // Unity gain and truncation cases, back to back at full rate.
        chk_lat = 1;
        step(1, 5 * 1024, 1024, 1, a);
        step(1, -1, 1024, 1, a);
        step(1, -1025, 1024, 1, a);
        step(1, -1024, 1024, 1, a);
        step(1, 1023, 1024, 1, a);
        step(1, 3 * 1024, -512, 1, a);
        step(1, -7 * 1024, 2048, 1, a);
        drain(0);
        chk("dout_hold", dout, last_val);
        chk("idle_valid", out_valid, 0);

        // Saturation in both directions; sat stays set.
        step(1, 40000 * 1024, 1024, 1, a);
        step(1, -40000 * 1024, 1024, 1, a);
        step(1, 2 * 1024, 1024, 1, a);
        drain(0);
        chk("sat_sticky", sat, 1);
        chk_lat = 0;

        // Reset with two samples in flight.
        step(1, 7 * 1024, 1024, 1, a);
        step(1, 8 * 1024, 1024, 1, a);
        @(negedge clock);
        reset_n = 0; in_valid = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_sat", sat, 0);
        sb.delete(); exp_sat = 0; hs_cnt = 0;
        @(negedge clock); reset_n = 1;
        step(1, 11 * 1024, 1024, 1, a);
        drain(0);
        chk("post_rst_first", last_val, 11);

        // Block count: 9 samples -> pulses on the 4th and 8th handshakes only.
        @(negedge clock); reset_n = 0;
        sb.delete(); exp_sat = 0; hs_cnt = 0;
        @(negedge clock); reset_n = 1;
        bd_seen = 0;
        for (int i = 0; i < 9; i++) step(1, (i + 1) * 1024, 1024, 1, a);
        drain(0);
        chk("block_pulses", bd_seen, 2);

        // Ramp 0..99 under random backpressure.
        idx = 0; guard = 0;
        while (idx < 100 && guard < 2000) begin
            step(1, idx * 1024, 1024, 1'($urandom_range(0, 1)), a);
            if (a) idx++;
            guard++;
        end
        chk("ramp_sent", idx, 100);
        drain(1);
        chk("ramp_last", last_val, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
